// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues at most one outstanding
// instruction-memory request, and feeds the IF/ID pipeline register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no request outstanding; issue a fetch for PCF unless redirected
// WAIT    | request outstanding; response is for the current PCF
// DISCARD | request outstanding but the stream was redirected; drop response
// HOLD    | response captured in the hold buffer; waiting for the pipe to advance
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
   output logic        FetchPending
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic        stale_q, stale_d;
   logic [31:0] instr_q, pcd_q, pcplus4_q;
   logic        valid_q;

   logic        advance;
   logic        deliver;
   logic        req;
   logic        pending;
   logic [31:0] deliver_data;
   logic [31:0] pc_plus4;

   assign advance  = !StallF && !StallD;
   assign pc_plus4 = pc_q + 32'd4;
   assign pending  = (state_q == S_WAIT) || (state_q == S_DISCARD);

   // Next-state, PC and hold-buffer logic.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_d       = hold_q;
      req          = 1'b0;
      deliver      = 1'b0;
      deliver_data = hold_q;
      unique case (state_q)
         S_IDLE: begin
            if (PCSrcE) begin
               pc_d = PCTargetE;
            end else if (!stale_q) begin
               req     = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (PCSrcE) begin
                  pc_d    = PCTargetE;
                  state_d = S_IDLE;
               end else if (advance) begin
                  deliver      = 1'b1;
                  deliver_data = imem_rdata;
                  state_d      = S_IDLE;
                  // A flushed delivery is lost, so the same PC is refetched.
                  if (!FlushD) pc_d = pc_plus4;
               end else begin
                  hold_d  = imem_rdata;
                  state_d = S_HOLD;
               end
            end else if (PCSrcE) begin
               pc_d    = PCTargetE;
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (PCSrcE) pc_d = PCTargetE;
            if (imem_rvalid) state_d = S_IDLE;
         end
         S_HOLD: begin
            if (PCSrcE) begin
               pc_d    = PCTargetE;
               state_d = S_IDLE;
            end else if (advance) begin
               deliver = 1'b1;
               state_d = S_IDLE;
               if (!FlushD) pc_d = pc_plus4;
            end
         end
         default: state_d = S_IDLE;
      endcase
      stale_d = stale_q && !imem_rvalid;
   end

   // State, PC and hold buffer registers. The stale flag remembers a request
   // left outstanding across reset so its late response is not mistaken for a
   // new fetch; fetching resumes once that response has been seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         hold_q  <= NOP_INSTR;
         stale_q <= (stale_q || pending) && !imem_rvalid;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         stale_q <= stale_d;
      end
   end

   // IF/ID register: flush beats stall beats delivery; otherwise a bubble.
   always_ff @(posedge clk) begin
      if (rst || FlushD) begin
         instr_q   <= NOP_INSTR;
         pcd_q     <= 32'd0;
         pcplus4_q <= 32'd0;
         valid_q   <= 1'b0;
      end else if (StallD) begin
         instr_q   <= instr_q;
         pcd_q     <= pcd_q;
         pcplus4_q <= pcplus4_q;
         valid_q   <= valid_q;
      end else if (deliver) begin
         instr_q   <= deliver_data;
         pcd_q     <= pc_q;
         pcplus4_q <= pc_plus4;
         valid_q   <= 1'b1;
      end else begin
         instr_q   <= NOP_INSTR;
         pcd_q     <= 32'd0;
         pcplus4_q <= 32'd0;
         valid_q   <= 1'b0;
      end
   end

   assign imem_req     = req && !rst;
   assign imem_addr    = pc_q;
   assign InstrD       = instr_q;
   assign PCD          = pcd_q;
   assign PCPlus4D     = pcplus4_q;
   assign ValidD       = valid_q;
   assign FetchPending = pending;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small fixed-latency memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD, FetchPending;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat     = 1;
   int          cnt     = 0;
   bit          has     = 0;
   logic [31:0] pend_addr = 32'd0;
   logic        req_seen;
   logic [31:0] addr_seen;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .PCSrcE       (PCSrcE),
      .PCTargetE    (PCTargetE),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .InstrD       (InstrD),
      .PCD          (PCD),
      .PCPlus4D     (PCPlus4D),
      .ValidD       (ValidD),
      .FetchPending (FetchPending)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return 32'hAAAA_0001 + a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample the request mid-cycle, then update the memory model
   // just after the rising edge (response 'lat' cycles after the request).
   task automatic step();
      @(negedge clk);
      req_seen  = imem_req;
      addr_seen = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (req_seen) begin
         has       = 1;
         cnt       = lat;
         pend_addr = addr_seen;
      end
      if (has) begin
         cnt--;
         if (cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend_addr);
            has         = 0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
      PCTargetE = 32'd0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

      // Reset state
      step(); step();
      check("rst_req", imem_req, 0);
      check("rst_valid", ValidD, 0);
      check("rst_instr", InstrD, 32'h0000_0013);
      check("rst_pcd", PCD, 0);
      check("rst_pcp4", PCPlus4D, 0);
      check("rst_pend", FetchPending, 0);

      // Basic fetch with 1-cycle memory
      rst = 1'b0; #1;
      check("f0_req", imem_req, 1);
      check("f0_addr", imem_addr, 0);
      step();
      check("f0_pend", FetchPending, 1);
      step();
      check("f0_instr", InstrD, 32'hAAAA_0001);
      check("f0_pcd", PCD, 0);
      check("f0_pcp4", PCPlus4D, 4);
      check("f0_valid", ValidD, 1);
      check("f1_req", imem_req, 1);
      check("f1_addr", imem_addr, 4);

      // Stall while the response arrives -> HOLD, then release
      StallF = 1'b1; StallD = 1'b1;
      step();
      step();
      check("hold_pend", FetchPending, 0);
      check("hold_instr", InstrD, 32'hAAAA_0001);
      check("hold_valid", ValidD, 1);
      step(); step();
      check("hold_instr2", InstrD, 32'hAAAA_0001);
      check("hold_pcd", PCD, 0);
      check("hold_req", imem_req, 0);
      StallF = 1'b0; StallD = 1'b0;
      step();
      check("rel_instr", InstrD, 32'hAAAA_0005);
      check("rel_pcd", PCD, 4);
      check("rel_pcp4", PCPlus4D, 8);
      check("rel_valid", ValidD, 1);
      check("rel_addr", imem_addr, 8);
      check("rel_req", imem_req, 1);

      // Flush together with stall and an arriving response
      StallD = 1'b1;
      step();
      check("fl_pre_valid", ValidD, 1);
      FlushD = 1'b1;
      step();
      check("fl_valid", ValidD, 0);
      check("fl_instr", InstrD, 32'h0000_0013);
      check("fl_pcd", PCD, 0);
      check("fl_pcp4", PCPlus4D, 0);
      FlushD = 1'b0; StallD = 1'b0;
      step();
      check("fl_rel_instr", InstrD, 32'hAAAA_0009);
      check("fl_rel_pcd", PCD, 8);

      // Redirect while waiting; late response must be dropped
      lat = 2;
      step();
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
      step();
      check("rd_pend", FetchPending, 1);
      check("rd_valid", ValidD, 0);
      PCSrcE = 1'b0;
      step();
      check("rd_valid2", ValidD, 0);
      check("rd_addr", imem_addr, 32'h0000_0100);
      check("rd_req", imem_req, 1);

      // PC wrap at the top of the address space
      lat = 1;
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; #1;
      check("wr_noreq", imem_req, 0);
      step();
      PCSrcE = 1'b0; #1;
      check("wr_req", imem_req, 1);
      check("wr_addr", imem_addr, 32'hFFFF_FFFC);
      step(); step();
      check("wr_instr", InstrD, 32'hAAA9_FFFD);
      check("wr_pcd", PCD, 32'hFFFF_FFFC);
      check("wr_pcp4", PCPlus4D, 0);
      check("wr_next", imem_addr, 0);

      // Reset while a request is outstanding; its response must be ignored
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
      step();
      PCSrcE = 1'b0;
      lat = 3;
      step();
      check("rw_pend", FetchPending, 1);
      rst = 1'b1;
      step();
      rst = 1'b0; #1;
      check("rw_req0", imem_req, 0);
      check("rw_pend0", FetchPending, 0);
      check("rw_addr", imem_addr, 0);
      step();
      check("rw_old_rv", imem_rvalid, 1);
      check("rw_req1", imem_req, 0);
      check("rw_valid", ValidD, 0);
      step();
      check("rw_req2", imem_req, 1);
      check("rw_addr2", imem_addr, 0);
      lat = 1;
      step(); step();
      check("rw_instr", InstrD, 32'hAAAA_0001);
      check("rw_pcd", PCD, 0);
      check("rw_valid2", ValidD, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, bubble encoding placed in InstrD.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 StallF  input  1  hazard-unit fetch stall; blocks PC advance and IF/ID load.
REQ-006 StallD  input  1  hazard-unit decode stall; holds IF/ID contents.
REQ-007 FlushD  input  1  hazard-unit decode flush; IF/ID becomes bubble.
REQ-008 PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-009 PCTargetE  input  32  redirect target, valid when PCSrcE=1.
REQ-010 imem_req  output  1  instruction fetch request; memory accepts it in the same cycle.
REQ-011 imem_addr  output  32  fetch address, equal to PCF while imem_req=1.
REQ-012 imem_rvalid  input  1  fetch response valid; at most one response per request, arriving 1 or more cycles after it.
REQ-013 imem_rdata  input  32  fetched instruction, valid when imem_rvalid=1.
REQ-014 InstrD  output  32  IF/ID instruction.
REQ-015 PCD  output  32  IF/ID PC.
REQ-016 PCPlus4D  output  32  IF/ID PC+4.
REQ-017 ValidD  output  1  IF/ID holds a real instruction.
REQ-018 FetchPending  output  1  high in WAIT or DISCARD.

Function
REQ-019 The block SHALL use four states: IDLE, WAIT, DISCARD and HOLD, with at most one outstanding request.
REQ-020 "Advance" SHALL mean StallF=0 and StallD=0.
REQ-021 IDLE: if PCSrcE=0, the block SHALL assert imem_req with imem_addr=PCF and go to WAIT; if PCSrcE=1, it SHALL issue no request, load PCF<=PCTargetE and stay in IDLE.
REQ-022 WAIT without rvalid: if PCSrcE=1, the block SHALL load PCF<=PCTargetE and go to DISCARD; otherwise it SHALL stay in WAIT.
REQ-023 WAIT with rvalid and PCSrcE=1: the block SHALL drop the data, load PCF<=PCTargetE and go to IDLE.
REQ-024 WAIT with rvalid, PCSrcE=0 and advance: the block SHALL load InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4 and ValidD=1, set PCF<=PCF+4 and go to IDLE.
REQ-025 WAIT with rvalid, PCSrcE=0 and no advance: the block SHALL capture rdata into a 32-bit hold buffer and go to HOLD.
REQ-026 HOLD: if PCSrcE=1, the block SHALL drop the buffer, load PCF<=PCTargetE and go to IDLE.
REQ-027 HOLD: else on advance, the block SHALL load IF/ID from the buffer as in REQ-024, set PCF<=PCF+4 and go to IDLE; otherwise it SHALL stay in HOLD.
REQ-028 DISCARD: on rvalid the block SHALL drop the data and go to IDLE; a further PCSrcE in DISCARD SHALL update PCF<=PCTargetE.
REQ-029 IF/ID priority: FlushD=1 SHALL force a bubble (InstrD=NOP_INSTR, ValidD=0, PCD=0, PCPlus4D=0) regardless of StallD or delivery; delivered data is lost and PCF SHALL NOT advance for it.
REQ-030 Otherwise, with StallD=1 the IF/ID register SHALL hold its contents.
REQ-031 Otherwise, with StallD=0 and no delivery that cycle, IF/ID SHALL load a bubble.
REQ-032 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-033 Best-case throughput SHALL be one instruction per 2 cycles with a 1-cycle memory.

Reset
REQ-034 With rst=1 at a clock edge, the block SHALL set state=IDLE, PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0 and ValidD=0, regardless of other inputs.
REQ-035 During reset, imem_req SHALL be 0.
REQ-036 A response arriving after reset from a pre-reset request SHALL be ignored.
REQ-037 FetchPending SHALL be 0 out of reset.

Verification
REQ-038 Reset, then 1-cycle memory returning 0xAAAA0001 for address 0 -> imem_req/addr=0 in cycle 1; InstrD=0xAAAA0001, PCD=0, PCPlus4D=4, ValidD=1 after cycle 2; next imem_addr=4.
REQ-039 StallD=StallF=1 while rvalid arrives, held for 3 cycles -> HOLD entered; IF/ID unchanged; after release, IF/ID gets the buffered instruction and PCF advances by 4.
REQ-040 PCSrcE=1 with PCTargetE=0x100 while in WAIT, response 2 cycles later -> response dropped (ValidD stays 0); next imem_addr=0x100.
REQ-041 rvalid, FlushD=1 and StallD=1 in the same cycle -> IF/ID becomes bubble (ValidD=0, InstrD=0x00000013).
REQ-042 PCF=0xFFFFFFFC and delivery occurs -> PCPlus4D=0 and next imem_addr=0.
REQ-043 rst=1 asserted in WAIT, then an old response arrives -> response ignored; first fetch is at RESET_PC.
